// File: rtl/spike_pkt_pkg.sv
// Shared constants, state encoding and packet-length helper for the spike packet writer.
package spike_pkt_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hA5A5;
  localparam int          HDR_WORDS = 3;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    HDR,
    DATA,
    TRL,
    DONE
  } state_t;

  // Words in one packet: optional header, one word per DATA_W channels, one trailer.
  function automatic int pkt_words(input int hdr_en, input int num_ch, input int data_w);
    return HDR_WORDS * hdr_en + num_ch / data_w + 1;
  endfunction

endpackage

// File: rtl/spike_packet_writer_popcount.sv
// Per-beat population count of one FIFO-width slice of the spike snapshot.
module word_popcount #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  word,
  output logic [CW-1:0] count
);

  // Count set bits in a single data word; the top-level accumulates across beats.
  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) count = count + CW'(word[i]);
  end

endmodule

// File: rtl/spike_packet_writer.sv
// Frames a snapshot of spike flags into a FIFO packet: header, data words, popcount trailer.
module spike_packet_writer
  import spike_pkt_pkg::*;
#(
  parameter int NUM_CH   = 128,
  parameter int DATA_W   = 16,
  parameter int LEAD_GAP = 2,
  parameter int HDR_EN   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [NUM_CH-1:0] spike_vec,
  input  logic [31:0]       timestamp,
  input  logic              fifo_ready,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              pkt_done,
  output logic              busy,
  output logic              drop,
  output logic [15:0]       drop_cnt
);

  localparam int DATA_WORDS = pkt_words(HDR_EN, NUM_CH, DATA_W) - HDR_WORDS * HDR_EN - 1;
  localparam int IDX_MAX    = (DATA_WORDS > HDR_WORDS) ? DATA_WORDS : HDR_WORDS;
  localparam int IDX_W      = $clog2(IDX_MAX + 1);
  localparam int ACC_W      = $clog2(NUM_CH + 1);
  localparam int PC_W       = $clog2(DATA_W + 1);
  localparam int CMP_W      = ACC_W + DATA_W;

  state_t              state, nxt;
  logic [NUM_CH-1:0]   snap;
  logic [31:0]         ts;
  logic [3:0]          gap_cnt;
  logic [IDX_W-1:0]    idx;
  logic [ACC_W-1:0]    acc;
  logic [PC_W-1:0]     pc;
  logic                wr, load, beat;
  logic [DATA_W-1:0]   word;

  // Snapshot is shifted down one word per data beat, so the low slice is always the next word.
  word_popcount #(.W(DATA_W), .CW(PC_W)) u_pc (
    .word  (snap[DATA_W-1:0]),
    .count (pc)
  );

  assign busy = (state != IDLE);

  // Next-state and per-cycle write decision; writes only happen on fifo_ready in emitting states.
  always_comb begin
    nxt  = state;
    wr   = 1'b0;
    load = 1'b0;
    beat = 1'b0;
    word = '0;
    case (state)
      IDLE: if (start) begin
        load = 1'b1;
        if (LEAD_GAP != 0)    nxt = GAP;
        else if (HDR_EN != 0) nxt = HDR;
        else                  nxt = DATA;
      end
      GAP: if (gap_cnt == 4'(LEAD_GAP - 1)) nxt = (HDR_EN != 0) ? HDR : DATA;
      HDR: if (fifo_ready) begin
        wr = 1'b1;
        if (idx == '0)                      word = DATA_W'(SYNC_WORD);
        else if (idx == IDX_W'(1))          word = DATA_W'(ts[31:16]);
        else                                word = DATA_W'(ts[15:0]);
        if (idx == IDX_W'(HDR_WORDS - 1))   nxt  = DATA;
      end
      DATA: if (fifo_ready) begin
        wr   = 1'b1;
        beat = 1'b1;
        word = snap[DATA_W-1:0];
        if (idx == IDX_W'(DATA_WORDS - 1)) nxt = TRL;
      end
      TRL: if (fifo_ready) begin
        wr  = 1'b1;
        nxt = DONE;
        // Saturate the channel count to the largest value a data word can carry.
        if (CMP_W'(acc) > CMP_W'({DATA_W{1'b1}})) word = '1;
        else                                      word = DATA_W'(acc);
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State, registered outputs, snapshot and running popcount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_en    <= 1'b0;
      wr_data  <= '0;
      pkt_done <= 1'b0;
      drop     <= 1'b0;
      drop_cnt <= '0;
      snap     <= '0;
      ts       <= '0;
      gap_cnt  <= '0;
      idx      <= '0;
      acc      <= '0;
    end else begin
      state    <= nxt;
      wr_en    <= wr;
      wr_data  <= word;
      pkt_done <= (state == DONE);
      drop     <= start && (state != IDLE);
      if (start && (state != IDLE) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      gap_cnt  <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (nxt != state) idx <= '0;
      else if (wr)      idx <= idx + IDX_W'(1);
      if (load) begin
        snap <= spike_vec;
        ts   <= timestamp;
        acc  <= '0;
      end else if (beat) begin
        snap <= snap >> DATA_W;
        acc  <= acc + ACC_W'(pc);
      end
    end
  end

endmodule

// File: tb/tb_spike_packet_writer.sv
// Directed bench: default packet, backpressure, start rejection, reset abort, headerless config.
module tb_spike_packet_writer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, fifo_ready;
  logic [127:0] spike_vec;
  logic [31:0]  timestamp;
  logic         wr_en, pkt_done, busy, drop;
  logic [15:0]  wr_data, drop_cnt;

  logic         start1, fifo_ready1;
  logic [63:0]  spike_vec1;
  logic [31:0]  timestamp1;
  logic         wr_en1, pkt_done1, busy1, drop1;
  logic [15:0]  wr_data1, drop_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spike_packet_writer u_dut (
    .clk(clk), .rst(rst), .start(start), .spike_vec(spike_vec), .timestamp(timestamp),
    .fifo_ready(fifo_ready), .wr_en(wr_en), .wr_data(wr_data), .pkt_done(pkt_done),
    .busy(busy), .drop(drop), .drop_cnt(drop_cnt)
  );

  spike_packet_writer #(.NUM_CH(64), .DATA_W(16), .LEAD_GAP(0), .HDR_EN(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .spike_vec(spike_vec1), .timestamp(timestamp1),
    .fifo_ready(fifo_ready1), .wr_en(wr_en1), .wr_data(wr_data1), .pkt_done(pkt_done1),
    .busy(busy1), .drop(drop1), .drop_cnt(drop_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected packet word i for the default configuration.
  function automatic logic [15:0] exp_word(input int i, input logic [127:0] v, input logic [31:0] t);
    case (i)
      0:       return 16'hA5A5;
      1:       return t[31:16];
      2:       return t[15:0];
      11:      return 16'($countones(v));
      default: return v[(i-3)*16 +: 16];
    endcase
  endfunction

  // Start at cycle 0 with fifo_ready high; optional rejected starts land as drop pulses in rej_a/rej_b.
  task automatic run_std(input logic [127:0] vec, input logic [31:0] ts, input int rej_a, input int rej_b);
    spike_vec  = vec;
    timestamp  = ts;
    fifo_ready = 1'b1;
    start      = 1'b1;
    step();
    start      = 1'b0;
    spike_vec  = ~vec;
    timestamp  = ~ts;
    for (int c = 0; c <= 16; c++) begin
      chk($sformatf("wr_en c%0d", c), wr_en, (c >= 3 && c <= 14));
      chk($sformatf("wr_data c%0d", c), wr_data, (c >= 3 && c <= 14) ? exp_word(c - 3, vec, ts) : 16'h0);
      chk($sformatf("pkt_done c%0d", c), pkt_done, (c == 15));
      chk($sformatf("busy c%0d", c), busy, (c <= 14));
      chk($sformatf("drop c%0d", c), drop, (c == rej_a || c == rej_b));
      start = (c + 1 == rej_a || c + 1 == rej_b);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] q[$];
    logic [127:0] ones;
    logic [127:0] v4;
    int bad_zero, wcnt;
    bit done;
    ones = '1;
    rst = 1'b1; start = 0; fifo_ready = 0; spike_vec = '0; timestamp = '0;
    start1 = 0; fifo_ready1 = 0; spike_vec1 = '0; timestamp1 = '0;
    step(); step();
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 0);
    chk("rst pkt_done", pkt_done, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst busy1", busy1, 0);
    chk("rst drop_cnt1", drop_cnt1, 0);
    rst = 1'b0;
    step();

    // Default packet with a single spike on channel 0.
    run_std(128'h1, 32'h0001_0002, -1, -1);

    // All channels firing, FIFO ready every other cycle.
    spike_vec = ones; timestamp = 32'hDEAD_BEEF; fifo_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0; spike_vec = '0;
    done = 0; bad_zero = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (wr_en) q.push_back(wr_data);
      else if (wr_data !== 16'h0) bad_zero++;
      if (pkt_done) done = 1;
      fifo_ready = ~fifo_ready;
      step();
    end
    fifo_ready = 1'b1;
    chk("bp done seen", done, 1);
    chk("bp word count", q.size(), 12);
    chk("bp idle data zero", bad_zero, 0);
    for (int i = 0; i < 12; i++)
      chk($sformatf("bp word %0d", i), (i < q.size()) ? q[i] : 16'hBAD0, exp_word(i, ones, 32'hDEAD_BEEF));
    chk("bp trailer", exp_word(11, ones, 0), 16'h0080);
    step();

    // Starts at cycle 5 and during DONE are both rejected.
    run_std(128'h8000_0000_0000_0000_0000_0000_0003_F00F, 32'h1234_5678, 5, 15);
    chk("drop_cnt after rejects", drop_cnt, 2);

    // Reset while data word 4 is on the bus.
    v4 = 128'h0;
    v4[64 +: 16] = 16'h1234;
    v4[0 +: 16]  = 16'h00FF;
    spike_vec = v4; timestamp = 32'hCAFE_0001; start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre-rst wr_en", wr_en, 1);
    chk("pre-rst wr_data", wr_data, 16'h1234);
    rst = 1'b1;
    #1;
    chk("mid-rst wr_en", wr_en, 0);
    chk("mid-rst wr_data", wr_data, 0);
    chk("mid-rst busy", busy, 0);
    chk("mid-rst drop_cnt", drop_cnt, 0);
    step();
    rst = 1'b0;
    wcnt = 0;
    repeat (8) begin
      step();
      if (wr_en) wcnt++;
    end
    chk("post-rst writes", wcnt, 0);
    run_std(v4, 32'hCAFE_0001, -1, -1);

    // Headerless, no lead gap, 64 channels.
    spike_vec1 = 64'h0000_0003_0000_0081; fifo_ready1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0; spike_vec1 = '0;
    for (int c = 0; c <= 7; c++) begin
      logic [15:0] e;
      case (c)
        1: e = 16'h0081;
        3: e = 16'h0003;
        5: e = 16'h0004;
        default: e = 16'h0000;
      endcase
      chk($sformatf("u1 wr_en c%0d", c), wr_en1, (c >= 1 && c <= 5));
      chk($sformatf("u1 wr_data c%0d", c), wr_data1, e);
      chk($sformatf("u1 pkt_done c%0d", c), pkt_done1, (c == 6));
      chk($sformatf("u1 drop c%0d", c), drop1, 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
